// File: rtl/gift128_pkg.sv
// Shared GIFT-128 definitions: round count, constant seed, FSM encodings and the
// S-box / bit-permutation helpers used by the encryption round.
package gift128_pkg;

   localparam int unsigned ROUNDS  = 40;
   localparam logic [5:0]  RC_INIT = 6'h01;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RND_OP = 2'd1,
      DONE   = 2'd2
   } fsm_e;

   function automatic logic [3:0] gift_sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h1;
         4'h1: y = 4'ha;
         4'h2: y = 4'h4;
         4'h3: y = 4'hc;
         4'h4: y = 4'h6;
         4'h5: y = 4'hf;
         4'h6: y = 4'h3;
         4'h7: y = 4'h9;
         4'h8: y = 4'h2;
         4'h9: y = 4'hd;
         4'ha: y = 4'hb;
         4'hb: y = 4'h7;
         4'hc: y = 4'h5;
         4'hd: y = 4'h0;
         4'he: y = 4'h8;
         default: y = 4'he;
      endcase
      return y;
   endfunction

   // Pure wiring: every destination index is a constant after loop unrolling.
   function automatic logic [127:0] gift_perm(input logic [127:0] s);
      logic [127:0] p;
      logic [6:0]   dst;
      p = '0;
      for (int i = 0; i < 128; i++) begin
         dst    = 7'(4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4));
         p[dst] = s[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/gift128_enc_round.sv
// One combinational GIFT-128 encryption round, including the on-the-fly key
// schedule step and the round-constant LFSR step.
module gift128_enc_round
   import gift128_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] rk_i,
   input  logic [5:0]   rc_i,
   output logic [127:0] state_o,
   output logic [127:0] rk_o,
   output logic [5:0]   rc_o
);

   logic [127:0] sc;
   logic [127:0] ark;

   always_comb begin
      sc = '0;
      for (int n = 0; n < 32; n++) begin
         sc[4*n +: 4] = gift_sbox(state_i[4*n +: 4]);
      end
      ark = gift_perm(sc);
      // U = rk[95:64] lands on bit 4i+2, V = rk[31:0] on bit 4i+1.
      for (int i = 0; i < 32; i++) begin
         ark[4*i+2] = ark[4*i+2] ^ rk_i[64+i];
         ark[4*i+1] = ark[4*i+1] ^ rk_i[i];
      end
      ark[127] = ~ark[127];
      for (int j = 0; j < 6; j++) begin
         ark[4*j+3] = ark[4*j+3] ^ rc_i[j];
      end
   end

   assign state_o = ark;
   assign rk_o    = {rk_i[17:16], rk_i[31:18], rk_i[11:0], rk_i[15:12], rk_i[127:32]};
   assign rc_o    = {rc_i[4:0], rc_i[5] ^ rc_i[4] ^ 1'b1};

endmodule

// File: rtl/gift_128_enc.sv
// GIFT-128 encryption core, one round per clock; define GIFT128_ENC_UNROLL2_EN
// to chain two rounds per clock.  States: IDLE | wait for key_ld/enc_start,
// RND_OP | rounds in progress, DONE | one-cycle enc_done pulse.
module gift_128_enc
   import gift128_pkg::*;
(
   input  logic         clk_i,
   input  logic         reset_n,
   output logic         busy,
   input  logic [127:0] key_in,
   input  logic         key_ld,
   output logic         key_valid,
   input  logic [127:0] plain_in,
   input  logic         enc_start,
   output logic [127:0] cipher_out,
   output logic         enc_done
);

   fsm_e         fsm_q, fsm_d;
   logic [127:0] key_q, key_d;
   logic         key_valid_q, key_valid_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rk_q, rk_d;
   logic [5:0]   rc_q, rc_d;
   logic [5:0]   cnt_q, cnt_d;

   logic [127:0] rnd_state;
   logic [127:0] rnd_rk;
   logic [5:0]   rnd_rc;

`ifdef GIFT128_ENC_UNROLL2_EN
   localparam logic [5:0] CNT_STEP = 6'd2;
   localparam logic [5:0] LAST_CNT = 6'(ROUNDS - 2);

   logic [127:0] mid_state;
   logic [127:0] mid_rk;
   logic [5:0]   mid_rc;

   gift128_enc_round u_rnd0 (
      .state_i (state_q),
      .rk_i    (rk_q),
      .rc_i    (rc_q),
      .state_o (mid_state),
      .rk_o    (mid_rk),
      .rc_o    (mid_rc)
   );

   gift128_enc_round u_rnd1 (
      .state_i (mid_state),
      .rk_i    (mid_rk),
      .rc_i    (mid_rc),
      .state_o (rnd_state),
      .rk_o    (rnd_rk),
      .rc_o    (rnd_rc)
   );
`else
   localparam logic [5:0] CNT_STEP = 6'd1;
   localparam logic [5:0] LAST_CNT = 6'(ROUNDS - 1);

   gift128_enc_round u_rnd0 (
      .state_i (state_q),
      .rk_i    (rk_q),
      .rc_i    (rc_q),
      .state_o (rnd_state),
      .rk_o    (rnd_rk),
      .rc_o    (rnd_rc)
   );
`endif

   always_ff @(posedge clk_i) begin
      if (!reset_n) begin
         fsm_q       <= IDLE;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         state_q     <= '0;
         rk_q        <= '0;
         rc_q        <= '0;
         cnt_q       <= '0;
      end else begin
         fsm_q       <= fsm_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         state_q     <= state_d;
         rk_q        <= rk_d;
         rc_q        <= rc_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      state_d     = state_q;
      rk_d        = rk_q;
      rc_d        = rc_q;
      cnt_d       = cnt_q;
      case (fsm_q)
         IDLE: begin
            // A key load in the same cycle as a start takes priority; the start is dropped.
            if (key_ld) begin
               key_d       = key_in;
               key_valid_d = 1'b1;
            end else if (enc_start) begin
               state_d = plain_in;
               rk_d    = key_q;
               rc_d    = RC_INIT;
               cnt_d   = '0;
               fsm_d   = RND_OP;
            end
         end
         RND_OP: begin
            state_d = rnd_state;
            rk_d    = rnd_rk;
            rc_d    = rnd_rc;
            cnt_d   = cnt_q + CNT_STEP;
            if (cnt_q == LAST_CNT) begin
               fsm_d = DONE;
            end
         end
         DONE: begin
            fsm_d = IDLE;
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   assign busy       = (fsm_q != IDLE);
   assign enc_done   = (fsm_q == DONE);
   assign key_valid  = key_valid_q;
   assign cipher_out = state_q;

endmodule
